// File: rtl/data_mem_resp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_pkg : shared types and constants for data_mem_resp          |
// | Rev 1.0  : initial release                                       |
// +------------------------------------------------------------------+
package dmem_pkg;

  localparam int c_CNT_W    = 4;
  localparam int c_WORD_LSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/data_mem_resp_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_mem_resp_if : load/store handshake between datapath & memory|
// | Optional err signal present with DMEM_ERR_EN                     |
// | Rev 1.0  : initial release                                       |
// +------------------------------------------------------------------+
interface data_mem_resp_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic        valid;
  logic [31:0] rdata;
`ifdef DMEM_ERR_EN
  logic        err;
`endif

  modport master (
    output req, we, addr, wdata, be,
    input  ready, valid, rdata
`ifdef DMEM_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, valid, rdata
`ifdef DMEM_ERR_EN
    , output err
`endif
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_resp_array.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_array : DEPTH x 32 synchronous RAM, byte writes, reg read   |
// | Rev 1.0    : initial release                                     |
// +------------------------------------------------------------------+
module dmem_array #(
  parameter int DEPTH = 256
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     wr_en_i,
  input  wire logic [3:0]               be_i,
  input  wire logic                     rd_en_i,
  input  wire logic                     clr_i,
  input  wire logic [$clog2(DEPTH)-1:0] addr_i,
  input  wire logic [31:0]              wdata_i,
  output logic      [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_resp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_mem_resp : multi-cycle handshaked data-memory responder     |
// | Optional access-error checking with DMEM_ERR_EN                  |
// | Rev 1.0       : initial release                                  |
// +------------------------------------------------------------------+
module data_mem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  wire logic       clk,
  input  wire logic       rst,
  data_mem_resp_if.slave  bus
);

  localparam int c_AW = $clog2(DEPTH);

  state_e               state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 we_q;
  logic [c_AW-1:0]      idx_q;
  logic [31:0]          wdata_q;
  logic [3:0]           be_q;
  logic                 err_q;

  logic                 w_idle;
  logic                 w_accept;
  logic                 w_commit;
  logic                 w_acc_err;
  logic                 w_op_we;
  logic                 w_op_err;
  logic [c_AW-1:0]      w_op_idx;
  logic [31:0]          w_op_wdata;
  logic [3:0]           w_op_be;
  logic [31:0]          w_rdata;

  assign w_idle   = (state_q == ST_IDLE);
  assign w_accept = w_idle && bus.req;

`ifdef DMEM_ERR_EN
  assign w_acc_err = (bus.addr[1:0] != 2'b00) ||
                     (|bus.addr[31:c_AW+c_WORD_LSB]);
`else
  logic w_unused_addr;
  assign w_acc_err     = 1'b0;
  assign w_unused_addr = ^{bus.addr[31:c_AW+c_WORD_LSB], bus.addr[1:0]};
`endif

  // With WAIT=0 the commit edge is the acceptance edge, so take live inputs.
  assign w_op_we    = w_idle ? bus.we : we_q;
  assign w_op_idx   = w_idle ? bus.addr[c_AW+c_WORD_LSB-1:c_WORD_LSB] : idx_q;
  assign w_op_wdata = w_idle ? bus.wdata : wdata_q;
  assign w_op_be    = w_idle ? bus.be : be_q;
  assign w_op_err   = w_idle ? w_acc_err : err_q;

  assign w_commit = (state_d == ST_RESP) && (state_q != ST_RESP) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          if (WAIT == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = c_CNT_W'(WAIT - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ready = w_idle && !rst;
    bus.valid = (state_q == ST_RESP);
`ifdef DMEM_ERR_EN
    bus.err   = (state_q == ST_RESP) && err_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else if (w_accept) begin
      we_q    <= bus.we;
      idx_q   <= bus.addr[c_AW+c_WORD_LSB-1:c_WORD_LSB];
      wdata_q <= bus.wdata;
      be_q    <= bus.be;
      err_q   <= w_acc_err;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (w_commit && w_op_we && !w_op_err),
    .be_i    (w_op_be),
    .rd_en_i (w_commit && !w_op_we),
    .clr_i   (w_commit && w_op_err),
    .addr_i  (w_op_idx),
    .wdata_i (w_op_wdata),
    .rdata_o (w_rdata)
  );

  assign bus.rdata = w_rdata;

endmodule
`default_nettype wire
